// File: rtl/oam_dma_controller_pkg.sv
// Memory-map constants and FSM encoding shared by the OAM DMA controller.
package oam_dma_controller_pkg;
  localparam logic [15:0] DMA_REG_DEF  = 16'hFF46;
  localparam logic [15:0] OAM_BASE_DEF = 16'hFE00;
  localparam logic [15:0] HRAM_LO_DEF  = 16'hFF80;
  localparam logic [15:0] HRAM_HI_DEF  = 16'hFFFE;
  localparam int          DMA_LEN_DEF  = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_e;
endpackage

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA sequencer: copies XX00-XX9F into OAM one byte per M-cycle and
// arbitrates the single memory port, restricting the CPU to HRAM while a copy runs.
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int                    ADDR_SIZE    = 16,
  parameter int                    DATA_SIZE    = 8,
  parameter logic [ADDR_SIZE-1:0]  DMA_REG_ADDR = DMA_REG_DEF,
  parameter logic [ADDR_SIZE-1:0]  OAM_BASE     = OAM_BASE_DEF,
  parameter int                    DMA_LEN      = DMA_LEN_DEF,
  parameter logic [ADDR_SIZE-1:0]  HRAM_LO      = HRAM_LO_DEF,
  parameter logic [ADDR_SIZE-1:0]  HRAM_HI      = HRAM_HI_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           t_cycle,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [DATA_SIZE-1:0] cpu_wdata,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  output logic [DATA_SIZE-1:0] cpu_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 dma_active,
  output logic                 dma_done
);
  dma_state_e           state, state_nxt;
  logic [DATA_SIZE-1:0] dma_reg, src, latch;
  logic [7:0]           idx;
  logic                 restart;
  logic                 reg_hit, reg_wr, last, m_end, cpu_slot, hram, cpu_fwd;

  assign reg_hit    = (cpu_addr == DMA_REG_ADDR);
  assign reg_wr     = cpu_wr && reg_hit;
  assign last       = (idx == 8'(DMA_LEN - 1));
  assign m_end      = (t_cycle == 2'd3);
  assign cpu_slot   = (t_cycle == 2'd0) || (t_cycle == 2'd3);
  assign hram       = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
  assign dma_active = (state == XFER);
  // FF46 is a register, never memory; otherwise the CPU owns the port unless a copy is running
  assign cpu_fwd    = !reg_hit && ((state != XFER) || (cpu_slot && hram));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dma_reg  <= '1;
      src      <= '0;
      idx      <= '0;
      restart  <= 1'b0;
      latch    <= '0;
      dma_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      dma_done <= 1'b0;
      if (reg_wr) dma_reg <= cpu_wdata;
      unique case (state)
        IDLE: if (reg_wr) src <= cpu_wdata;
        START: begin
          if (reg_wr) src <= cpu_wdata;
          if (m_end) idx <= '0;
        end
        XFER: begin
          if (t_cycle == 2'd1) latch <= mem_rdata;
          if (m_end) begin
            if (restart) begin
              src     <= dma_reg;
              idx     <= '0;
              restart <= reg_wr;
            end else if (last && reg_wr) begin
              // a write landing on the closing edge restarts without a completion pulse
              src <= cpu_wdata;
              idx <= '0;
            end else if (last) begin
              dma_done <= 1'b1;
            end else begin
              idx     <= idx + 8'd1;
              restart <= reg_wr;
            end
          end else if (reg_wr) begin
            restart <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    cpu_rdata = mem_rdata;
    unique case (state)
      IDLE:    if (reg_wr) state_nxt = START;
      START:   if (m_end) state_nxt = XFER;
      XFER:    if (m_end && !restart && last && !reg_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state == XFER && t_cycle == 2'd1) begin
      mem_addr = ADDR_SIZE'({src, idx});
      mem_rd   = 1'b1;
    end else if (state == XFER && t_cycle == 2'd2) begin
      mem_addr  = OAM_BASE + ADDR_SIZE'(idx);
      mem_wdata = latch;
      mem_wr    = 1'b1;
    end else if (cpu_fwd) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
    end
    if (reg_hit)       cpu_rdata = dma_reg;
    else if (!cpu_fwd) cpu_rdata = '1;
    if (!rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
    end
  end
endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomized scoreboard bench for oam_dma_controller with a behavioural memory-map model.
module tb_oam_dma_controller;
  logic        clk = 1'b0, rst = 1'b0;
  logic [1:0]  t_cycle = 2'd0;
  logic [15:0] cpu_addr = '0, mem_addr;
  logic [7:0]  cpu_wdata = '0, cpu_rdata, mem_wdata, mem_rdata;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0, mem_rd, mem_wr, dma_active, dma_done;
  int          cyc = 0;

  logic [7:0]  mem [0:65535];
  logic        bk_we = 1'b0;
  logic [15:0] bk_addr = '0;
  logic [7:0]  bk_data = '0;

  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  ref_dma_reg = 8'hFF;
  logic [7:0]  exp_q [$];
  logic [15:0] addr_q [$];
  int          n_chk = 0, n_pass = 0, done_cnt = 0, done_cyc = -1;

  oam_dma_controller dut (
    .clk(clk), .rst(rst), .t_cycle(t_cycle), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    t_cycle <= t_cycle + 2'd1;
    cyc     <= cyc + 1;
  end

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (bk_we)  mem[bk_addr]  <= bk_data;
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Reference view of what the CPU should see for an access in a given slot.
  function automatic logic [7:0] exp_read(input logic [15:0] a, input int s, input bit in_xfer);
    if (a == 16'hFF46) return ref_dma_reg;
    if (!in_xfer) return ref_mem[a];
    if ((s == 0 || s == 3) && a >= 16'hFF80 && a <= 16'hFFFE) return ref_mem[a];
    return 8'hFF;
  endfunction

  function automatic void ref_write(input logic [15:0] a, input logic [7:0] d, input int s,
                                    input bit in_xfer);
    if (a == 16'hFF46) ref_dma_reg = d;
    else if (!in_xfer || ((s == 0 || s == 3) && a >= 16'hFF80 && a <= 16'hFFFE)) ref_mem[a] = d;
  endfunction

  function automatic void ref_copy(input logic [7:0] page, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ref_mem[16'hFE00 + 16'(i)] = ref_mem[{page, 8'(i)}];
  endfunction

  task automatic monitor();
    logic [7:0] e;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (rst && cpu_rd) begin
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else begin
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          if (cpu_rdata !== e) $display("FAIL rd@%h: got %h expected %h", a, cpu_rdata, e);
          n_chk++;
          if (cpu_rdata === e) n_pass++;
        end
      end
      if (dma_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic bk_fill(input logic [15:0] a, input logic [7:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d; ref_mem[a] = d;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  task automatic cpu_op(input bit wr, input logic [15:0] a, input logic [7:0] d, input bit in_xfer);
    int s;
    s = int'(t_cycle);
    cpu_addr = a; cpu_wdata = d; cpu_rd = !wr; cpu_wr = wr;
    if (!wr) begin
      exp_q.push_back(exp_read(a, s, in_xfer));
      addr_q.push_back(a);
    end else ref_write(a, d, s, in_xfer);
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic wait_slot(input logic [1:0] s);
    while (t_cycle != s) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic verify_oam();
    for (int i = 0; i < 160; i++) cpu_op(1'b0, 16'hFE00 + 16'(i), 8'h00, 1'b0);
  endtask

  // Transfer must begin at the first M-cycle boundary after the START state is entered.
  task automatic start_dma(input logic [7:0] page, output int rise);
    int w, s, n, e;
    wait_slot(2'($urandom_range(0, 3)));
    w = cyc; s = int'(t_cycle);
    cpu_op(1'b1, 16'hFF46, page, 1'b0);
    n = 0;
    while (!dma_active && n < 8) begin @(posedge clk); #1; n++; end
    check("start_timeout", int'(dma_active), 1);
    rise = cyc;
    e = w + 2;
    while (((s + (e - w)) % 4) != 0) e++;
    check("rise_cyc", rise - w, e - w);
    check("rise_slot", int'(t_cycle), 0);
  endtask

  initial begin : main
    int rise, d0, k;
    bit wr;
    logic [15:0] a;
    logic [7:0] r;
    fork monitor(); join_none
    fork begin #2000000; $display("FAIL watchdog: got timeout expected finish"); $fatal; end join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wr", int'(mem_wr), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_active", int'(dma_active), 0);
    check("rst_done", int'(dma_done), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // idle passthrough
    bk_fill(16'hC000, 8'h5A);
    cpu_addr = 16'hC000; cpu_rd = 1'b1;
    exp_q.push_back(8'h5A); addr_q.push_back(16'hC000);
    #1;
    check("idle_mem_rd", int'(mem_rd), 1);
    check("idle_active", int'(dma_active), 0);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_op(1'b0, 16'hFF46, 8'h00, 1'b0);

    for (int i = 0; i < 128; i++) bk_fill(16'hFF80 + 16'(i), 8'($urandom));
    for (int i = 0; i < 160; i++) bk_fill(16'hFE00 + 16'(i), 8'($urandom));
    for (int i = 0; i < 160; i++) bk_fill({8'hC0, 8'(i)}, 8'(i) ^ 8'h3C);
    for (int i = 0; i < 160; i++) bk_fill({8'hD0, 8'(i)}, 8'($urandom));

    // full copy with CPU traffic during the transfer
    d0 = done_cnt;
    start_dma(8'hC0, rise);
    cpu_op(1'b0, 16'h8000, 8'h00, 1'b1);
    cpu_op(1'b1, 16'hC000, 8'h11, 1'b1);
    wait_slot(2'd0); cpu_op(1'b1, 16'hFF90, 8'($urandom), 1'b1);
    wait_slot(2'd3); cpu_op(1'b0, 16'hFF90, 8'h00, 1'b1);
    wait_slot(2'd1); cpu_op(1'b0, 16'hFF90, 8'h00, 1'b1);
    cpu_op(1'b0, 16'hFF46, 8'h00, 1'b1);
    while (cyc < rise + 600) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      k = $urandom_range(0, 4);
      wr = 1'($urandom_range(0, 1));
      r = 8'($urandom);
      case (k)
        0: a = {8'h80, r};
        1: a = {8'hC0, r};
        2: a = 16'hFF80 + 16'($urandom_range(0, 127));
        3: a = 16'hFE00 + 16'($urandom_range(0, 159));
        default: begin a = 16'hFF46; wr = 1'b0; end
      endcase
      cpu_op(wr, a, 8'($urandom), 1'b1);
    end
    wait_until(rise + 641);
    check("copy_done_cnt", done_cnt - d0, 1);
    check("copy_done_time", done_cyc - rise, 640);
    check("copy_active_end", int'(dma_active), 0);
    ref_copy(8'hC0, 0, 159);
    cpu_op(1'b0, 16'hC000, 8'h00, 1'b0);
    cpu_op(1'b0, 16'hFF90, 8'h00, 1'b0);
    verify_oam();

    // restart at idx 50
    d0 = done_cnt;
    start_dma(8'hC0, rise);
    wait_until(rise + 201);
    cpu_op(1'b1, 16'hFF46, 8'hD0, 1'b1);
    ref_copy(8'hC0, 0, 50);
    wait_until(rise + 204 + 641);
    check("rst_done_cnt_restart", done_cnt - d0, 1);
    check("restart_done_time", done_cyc - rise, 204 + 640);
    check("restart_active_end", int'(dma_active), 0);
    ref_copy(8'hD0, 0, 159);
    verify_oam();
    cpu_op(1'b0, 16'hFF46, 8'h00, 1'b0);

    // reset at idx 80
    for (int i = 0; i < 160; i++) bk_fill(16'hFE00 + 16'(i), 8'($urandom));
    d0 = done_cnt;
    start_dma(8'hC0, rise);
    wait_until(rise + 320);
    rst = 1'b0;
    #1;
    check("abort_mem_addr", int'(mem_addr), 0);
    check("abort_mem_wdata", int'(mem_wdata), 0);
    check("abort_mem_rd", int'(mem_rd), 0);
    check("abort_mem_wr", int'(mem_wr), 0);
    check("abort_active", int'(dma_active), 0);
    check("abort_done", int'(dma_done), 0);
    ref_dma_reg = 8'hFF;
    ref_copy(8'hC0, 0, 79);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    cpu_op(1'b0, 16'hFF46, 8'h00, 1'b0);
    verify_oam();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", int'(dma_active), 0);

    // FF46 write landing on the final t3 edge
    d0 = done_cnt;
    start_dma(8'hD0, rise);
    wait_until(rise + 639);
    cpu_op(1'b1, 16'hFF46, 8'hC0, 1'b1);
    check("edge_still_active", int'(dma_active), 1);
    check("edge_no_done", done_cnt - d0, 0);
    wait_until(rise + 1281);
    check("edge_done_cnt", done_cnt - d0, 1);
    check("edge_done_time", done_cyc - rise, 1280);
    ref_copy(8'hD0, 0, 159);
    ref_copy(8'hC0, 0, 159);
    verify_oam();

    repeat (2) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
